dmem_port_arbiter: RTL

Shares the single-port data RAM between the pipeline's MEM stage and the board display reader. The CPU always wins when it accesses memory. The display gets idle RAM cycles, either as a fixed-address peek or as a sequential 32-word scan. An optional starvation guard freezes the pipeline for one cycle so the display is never locked out. The block sits between the EX/MEM pipeline register outputs and the data RAM, and replaces the ad-hoc address mux on the RAM port.

---
 rtl/dmem_port_arbiter_pkg.sv | 19 +
 rtl/dmem_port_arbiter_scan.sv | 58 +++++
 rtl/dmem_port_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-RAM port arbiter: display mode
// encoding, display word geometry and word-to-byte address formation.
package dmem_port_arbiter_pkg;

    localparam int         NUM_WORDS = 32;
    localparam int         IDX_W     = 5;
    localparam logic [1:0] WORD_OFS  = 2'b00;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_PEEK = 2'd1,
        MODE_SCAN = 2'd2
    } mode_e;

    function automatic logic [31:0] word_byte_addr(input logic [IDX_W-1:0] idx);
        return {{(32-IDX_W-2){1'b0}}, idx, WORD_OFS};
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_scan.sv
// disp_scan_seq: scan index, dwell counter and scan request generation for
// the display reader. Counters freeze outside SCAN and restart on re-entry.
module disp_scan_seq
    import dmem_port_arbiter_pkg::*;
#(
    parameter int SCAN_DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_e            mode_i,
    input  logic             gnt_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             req_o
);

    localparam logic [7:0] DWELL_RLD = 8'(SCAN_DWELL - 1);

    mode_e            mode_q;
    logic [IDX_W-1:0] idx_q, idx_d, idx_cur;
    logic [7:0]       dwell_q, dwell_d, dwell_cur;
    logic             entering;

    // Entry is handled combinationally so the very first SCAN cycle already
    // requests word 0 instead of waiting one cycle for the registers to clear.
    assign entering  = (mode_i == MODE_SCAN) && (mode_q != MODE_SCAN);
    assign idx_cur   = entering ? '0 : idx_q;
    assign dwell_cur = entering ? '0 : dwell_q;
    assign idx_o     = idx_cur;
    assign req_o     = (mode_i == MODE_SCAN) && (dwell_cur == 8'd0);

    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        if (mode_i == MODE_SCAN) begin
            idx_d   = idx_cur;
            dwell_d = dwell_cur;
            if (req_o && gnt_i) begin
                idx_d   = IDX_W'((32'(idx_cur) + 1) % NUM_WORDS);
                dwell_d = DWELL_RLD;
            end else if (dwell_cur != 8'd0) begin
                dwell_d = dwell_cur - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
        end else begin
            mode_q  <= mode_i;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-RAM port arbiter: CPU MEM stage has priority, the display reader takes
// idle cycles. Define DISP_STARVE_GUARD_EN to add the forced-grant stall.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int SCAN_DWELL = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        disp_en,
    input  logic        disp_seq_en,
    input  logic [4:0]  disp_addr,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic [15:0] disp_data,
    output logic [4:0]  disp_idx,
    output logic        disp_valid
);

    if (SCAN_DWELL < 1 || SCAN_DWELL > 255 || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_param_check
        $error("dmem_port_arbiter: SCAN_DWELL and STARVE_MAX must lie in 1..255");
    end

    mode_e            mode;
    logic             cpu_acc, disp_req, disp_gnt, force_gnt, scan_req;
    logic [IDX_W-1:0] scan_idx, cur_idx;
    logic [15:0]      disp_data_q;
    logic [IDX_W-1:0] disp_idx_q;
    logic             disp_valid_q;

    // Held in IDLE during reset so the RAM port mirrors the CPU immediately.
    always_comb begin
        mode = MODE_IDLE;
        if (!reset) begin
            if (disp_seq_en)  mode = MODE_SCAN;
            else if (disp_en) mode = MODE_PEEK;
        end
    end

    disp_scan_seq #(.SCAN_DWELL(SCAN_DWELL)) u_scan (
        .clk    (clk),
        .rst    (reset),
        .mode_i (mode),
        .gnt_i  (disp_gnt),
        .idx_o  (scan_idx),
        .req_o  (scan_req)
    );

    assign cpu_acc  = cpu_re | cpu_we;
    assign cur_idx  = (mode == MODE_SCAN) ? scan_idx : disp_addr;
    assign disp_req = (mode == MODE_PEEK) || ((mode == MODE_SCAN) && scan_req);
    assign disp_gnt = disp_req && (!cpu_acc || force_gnt);

`ifdef DISP_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starve_q, starve_d;

    assign force_gnt = disp_req && (starve_q == STARVE_LIM);
    assign starve_d  = (disp_req && cpu_acc && !disp_gnt) ? starve_q + 8'd1 : 8'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign force_gnt = 1'b0;
`endif

    // A forced grant also masks the store; the frozen pipeline replays it.
    assign ram_addr  = disp_gnt ? word_byte_addr(cur_idx) : cpu_addr;
    assign ram_we    = cpu_we && !disp_gnt;
    assign ram_din   = cpu_wdata;
    assign cpu_rdata = ram_dout;
    assign cpu_stall = force_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_data_q  <= '0;
            disp_idx_q   <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            disp_valid_q <= disp_gnt;
            if (disp_gnt) begin
                disp_data_q <= ram_dout[15:0];
                disp_idx_q  <= cur_idx;
            end
        end
    end

    assign disp_data  = disp_data_q;
    assign disp_idx   = disp_idx_q;
    assign disp_valid = disp_valid_q;

endmodule
